cpu_stage_sequencer: RTL and testbench
======================================

Name: cpu_stage_sequencer

Overview:
- Timing generator directly upstream of the CPU control unit.
- Steps every instruction through four one-hot phases (fetch, getRegs, readMem, writeBack) and latches the fetched instruction word for the decoder.
- Stalls each phase on the memory start/busy handshake.
- Includes a busy watchdog, so a hung memory access aborts to fetch with a sticky error flag instead of locking the CPU.

Parameters:
INSTR_WIDTH, 32, width of fetched instruction word / memory q bus
TIMEOUT_W, 8, width of watchdog counter
TIMEOUT, 200, max cycles a single memory access may take before abort (must be less than 2^TIMEOUT_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately)
start  in  1  memory-access request from control unit for current phase (combinational from phase + opcode)
busy  in  1  memory controller busy; rises the cycle after an accepted start, falls when access is complete
q  in  INSTR_WIDTH  memory read data, valid in the cycle busy falls
fetch  out  1  phase: instruction fetch
getRegs  out  1  phase: register-file read
readMem  out  1  phase: memory read / stack op
writeBack  out  1  phase: memory write / register write
instr  out  INSTR_WIDTH  latched instruction word for the decoder
instr_done  out  1  one-cycle pulse on the last cycle of writeBack
mem_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (async, reset==0):
  - fetch=1; getRegs, readMem, writeBack = 0.
  - instr=0, instr_done=0, mem_timeout=0; internal seen_busy=0, wdog=0.
  - Deassertion is synchronous to clk in the design top; the first active edge starts a fetch.
- Phase outputs are registered and strictly one-hot at all times.
- State encoding: FETCH, GETREGS, READMEM, WRITEBACK. Each memory-capable phase has a WAIT sub-condition tracked by the seen_busy flag.
- Phase with start==0 (GETREGS always; READMEM/WRITEBACK when the opcode needs no memory):
  - Lasts exactly 1 cycle, then advances.
- Phase with start==1: stays in the phase until access completion.
  - Completion = seen_busy==1 && busy==0.
  - seen_busy is set on the first cycle busy==1 within the phase and cleared on any phase change.
  - Minimum memory phase = 3 cycles: start cycle, ≥1 busy cycle, completion cycle. Phase advances on the edge after completion.
- FETCH completion: instr <= q on the completion edge; GETREGS is entered on the same edge.
  - instr holds its value until the next fetch completion, including across a timeout.
- FETCH always expects start==1. If start==0 in FETCH, hold (no advance).
- Transitions: FETCH -> GETREGS -> READMEM -> WRITEBACK -> FETCH.
- instr_done is high during the final cycle of WRITEBACK (the cycle before returning to FETCH). It is not asserted on a timeout abort.
- Watchdog:
  - wdog counts cycles while the phase is waiting (start==1 and not complete) and resets to 0 on phase change.
  - When wdog == TIMEOUT-1 and the access is not complete: mem_timeout <= 1 (sticky until reset), go directly to FETCH, clear seen_busy.
  - instr is unchanged on timeout.
  - Completion in the same cycle as the timeout threshold: completion wins, no error.
- busy==1 while start==0 (stale busy from a previous access): ignored; seen_busy is not set.
- busy never falls (stuck high): the watchdog handles it.
- Reset mid-phase: immediate return to FETCH state with all registers cleared. The interrupted memory access is abandoned; the memory controller is reset by the same reset net.
- wdog saturates and never wraps; its width is TIMEOUT_W.

Decomposition:
- Shared package: phase state encoding constants (ST_FETCH, ST_GETREGS, ST_READMEM, ST_WRITEBACK) and the INSTR_* opcode constants already used by the control unit. Decoder and sequencer share one definition.
- One natural sub-module: mem_access_watch. It contains seen_busy, the completion detect and the watchdog counter, and outputs done/timeout to the phase FSM.

Test Plan:
- Reset then no memory latency: busy high 1 cycle per access, start high in all four phases, q=32'hA5A5_0001 at fetch completion -> each memory phase lasts 3 cycles; instr=32'hA5A5_0001 one cycle after fetch completes; instr_done pulse every 12 cycles.
- Arithmetic-type instr: start=1 only in FETCH, busy 2 cycles -> phases last 4,1,1,1 cycles; instr_done on cycle 7.
- Stale busy: busy=1 during GETREGS with start=0 -> GETREGS still 1 cycle; READMEM with start=1 needs a fresh busy rise.
- Timeout: TIMEOUT=8, start=1 in READMEM, busy stuck high -> after 8 cycles in READMEM, fetch=1 and mem_timeout=1; instr unchanged; no instr_done; mem_timeout stays 1 across subsequent instructions.
- Completion exactly at threshold (busy falls on cycle TIMEOUT with seen_busy) -> phase advances normally, mem_timeout stays 0.
- Async reset asserted mid-WRITEBACK wait -> outputs go to reset values without waiting for a clk edge; after release, normal fetch resumes with instr=0 until the first fetch completes.

Source files
------------

// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared definitions for the CPU stage sequencer and the control-unit decoder.
// Contents: phase state encoding, opcode constants, phase one-hot helper.
package cpu_stage_sequencer_pkg;

    // Instruction phase encoding; the decoder keys off the same values.
    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_GETREGS   = 2'd1,
        ST_READMEM   = 2'd2,
        ST_WRITEBACK = 2'd3
    } phase_e;

    localparam int unsigned PHASE_N = 4;

    // Bit positions of each phase inside the one-hot phase vector.
    localparam int unsigned PH_FETCH_BIT     = 0;
    localparam int unsigned PH_GETREGS_BIT   = 1;
    localparam int unsigned PH_READMEM_BIT   = 2;
    localparam int unsigned PH_WRITEBACK_BIT = 3;

    // Opcode field of the instruction word as used by the control unit.
    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] INSTR_NOP   = 4'h0;
    localparam logic [OPCODE_W-1:0] INSTR_ADD   = 4'h1;
    localparam logic [OPCODE_W-1:0] INSTR_SUB   = 4'h2;
    localparam logic [OPCODE_W-1:0] INSTR_AND   = 4'h3;
    localparam logic [OPCODE_W-1:0] INSTR_OR    = 4'h4;
    localparam logic [OPCODE_W-1:0] INSTR_LOAD  = 4'h5;
    localparam logic [OPCODE_W-1:0] INSTR_STORE = 4'h6;
    localparam logic [OPCODE_W-1:0] INSTR_PUSH  = 4'h7;
    localparam logic [OPCODE_W-1:0] INSTR_POP   = 4'h8;
    localparam logic [OPCODE_W-1:0] INSTR_JMP   = 4'h9;
    localparam logic [OPCODE_W-1:0] INSTR_JZ    = 4'hA;
    localparam logic [OPCODE_W-1:0] INSTR_HALT  = 4'hF;

    // One-hot phase vector for a phase state.
    function automatic logic [PHASE_N-1:0] phase_onehot(input phase_e ph);
        logic [PHASE_N-1:0] oh;
        oh = '0;
        case (ph)
            ST_FETCH:     oh[PH_FETCH_BIT]     = 1'b1;
            ST_GETREGS:   oh[PH_GETREGS_BIT]   = 1'b1;
            ST_READMEM:   oh[PH_READMEM_BIT]   = 1'b1;
            ST_WRITEBACK: oh[PH_WRITEBACK_BIT] = 1'b1;
            default:      oh[PH_FETCH_BIT]     = 1'b1;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cpu_stage_sequencer_mem_access_watch.sv
// Memory access tracker for one phase: remembers whether busy has been seen,
// detects access completion and runs the hung-access watchdog.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req          start from control unit (access requested in this phase)
//   busy         memory controller busy
//   phase_chg    phase is changing on the coming edge; clears tracking state
//   done_c       access complete this cycle (busy fell after being seen)
//   timeout_c    access still pending on its last allowed cycle
module mem_access_watch #(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic busy,
    input  logic phase_chg,
    output logic done_c,
    output logic timeout_c
);

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = {TIMEOUT_W{1'b1}};

    logic                 seen_busy_q, seen_busy_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 waiting_c;

    // Completion outranks the watchdog when both land on the same cycle.
    assign done_c    = req && seen_busy_q && !busy;
    assign waiting_c = req && !done_c;
    assign timeout_c = waiting_c && (wdog_q == WDOG_LAST);

    // Tracking state next value; busy without a request is stale and ignored.
    always_comb begin
        seen_busy_d = seen_busy_q;
        wdog_d      = wdog_q;
        if (phase_chg) begin
            seen_busy_d = 1'b0;
            wdog_d      = '0;
        end else begin
            if (req && busy) begin
                seen_busy_d = 1'b1;
            end
            if (waiting_c && (wdog_q != WDOG_MAX)) begin
                wdog_d = wdog_q + TIMEOUT_W'(1);
            end
        end
    end

    // Tracking state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_busy_q <= 1'b0;
            wdog_q      <= '0;
        end else begin
            seen_busy_q <= seen_busy_d;
            wdog_q      <= wdog_d;
        end
    end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Instruction phase sequencer in front of the CPU control unit. Steps each
// instruction through fetch, getRegs, readMem, writeBack, stalling on the
// memory start/busy handshake, and latches the fetched instruction word.
// A hung memory access aborts back to fetch and raises sticky mem_timeout.
// Ports:
//   clk          system clock
//   reset        async active-low reset (release expected aligned to clk)
//   start        memory request for the current phase
//   busy         memory controller busy
//   q            memory read data, valid when busy falls
//   fetch/getRegs/readMem/writeBack  registered one-hot phase
//   instr        latched instruction word
//   instr_done   high on the final cycle of writeBack (combinational)
//   mem_timeout  sticky watchdog error flag
module cpu_stage_sequencer
    import cpu_stage_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT     = 200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   busy,
    input  logic [INSTR_WIDTH-1:0] q,
    output logic                   fetch,
    output logic                   getRegs,
    output logic                   readMem,
    output logic                   writeBack,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_done,
    output logic                   mem_timeout
);

    phase_e                 state_q, state_d;
    logic [PHASE_N-1:0]     phase_q, phase_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic                   done_c, timeout_c, phase_chg_c;

    // Per-phase access tracking and watchdog.
    mem_access_watch #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_watch (
        .clk       (clk),
        .rst_n     (reset),
        .req       (start),
        .busy      (busy),
        .phase_chg (phase_chg_c),
        .done_c    (done_c),
        .timeout_c (timeout_c)
    );

    // Next phase, instruction latch, error flag and end-of-instruction pulse.
    // A phase without a request lasts one cycle; fetch always waits for one.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        mem_timeout_d = mem_timeout_q;
        instr_done    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (done_c) begin
                    state_d = ST_GETREGS;
                    instr_d = q;
                end
            end
            ST_GETREGS: begin
                if (!start || done_c) begin
                    state_d = ST_READMEM;
                end
            end
            ST_READMEM: begin
                if (!start || done_c) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                if (!start || done_c) begin
                    state_d    = ST_FETCH;
                    instr_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if (timeout_c) begin
            state_d       = ST_FETCH;
            instr_d       = instr_q;
            mem_timeout_d = 1'b1;
            instr_done    = 1'b0;
        end
        // An abort during fetch restarts fetch, so it counts as a phase change.
        phase_chg_c = timeout_c || (state_d != state_q);
        phase_d     = phase_onehot(state_d);
    end

    // Phase, instruction and error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            phase_q       <= phase_onehot(ST_FETCH);
            instr_q       <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            instr_q       <= instr_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign fetch       = phase_q[PH_FETCH_BIT];
    assign getRegs     = phase_q[PH_GETREGS_BIT];
    assign readMem     = phase_q[PH_READMEM_BIT];
    assign writeBack   = phase_q[PH_WRITEBACK_BIT];
    assign instr       = instr_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer: directed handshake vectors,
// a phase-level reference model checked every cycle, plus literal checks.
module tb_cpu_stage_sequencer;

    localparam int unsigned IW = 32;
    localparam int unsigned TO = 8;
    localparam logic [IW-1:0] JUNK = 32'hDEAD_0000;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic [IW-1:0] q;
    logic          fetch, getRegs, readMem, writeBack;
    logic [IW-1:0] instr;
    logic          instr_done;
    logic          mem_timeout;

    int checks = 0;
    int errors = 0;

    cpu_stage_sequencer #(
        .INSTR_WIDTH (IW),
        .TIMEOUT_W   (8),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .q           (q),
        .fetch       (fetch),
        .getRegs     (getRegs),
        .readMem     (readMem),
        .writeBack   (writeBack),
        .instr       (instr),
        .instr_done  (instr_done),
        .mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase index 0..3, busy-seen flag, pending-cycle count.
    int            m_phase;
    bit            m_seen;
    int            m_wait;
    logic [IW-1:0] m_instr;
    bit            m_to;

    always @(posedge clk or negedge reset) begin
        bit req, comp;
        if (!reset) begin
            m_phase = 0; m_seen = 0; m_wait = 0; m_instr = '0; m_to = 0;
        end else begin
            req  = start;
            comp = req && m_seen && !busy;
            if (req && !comp && (m_wait + 1 == TO)) begin
                m_to = 1; m_phase = 0; m_seen = 0; m_wait = 0;
            end else if (comp || (m_phase != 0 && !req)) begin
                if (m_phase == 0) m_instr = q;
                m_phase = (m_phase + 1) % 4;
                m_seen = 0; m_wait = 0;
            end else begin
                if (req) m_wait++;
                if (req && busy) m_seen = 1;
            end
        end
    end

    // Per-cycle comparison and instr_done bookkeeping.
    int cyc_n = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;

    always @(negedge clk) begin
        logic [3:0] exp_ph;
        logic       exp_done;
        cyc_n++;
        exp_ph   = 4'b0001 << m_phase;
        exp_done = reset && (m_phase == 3) && (!start || (m_seen && !busy));
        chk("phase", IW'({writeBack, readMem, getRegs, fetch}), IW'(exp_ph));
        chk("instr", instr, m_instr);
        chk("instr_done", IW'(instr_done), IW'(exp_done));
        chk("mem_timeout", IW'(mem_timeout), IW'(m_to));
        if (instr_done === 1'b1) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc_n;
        end
    end

    task automatic cyc(input bit s, input bit b, input logic [IW-1:0] qv);
        start = s; busy = b; q = qv;
        @(posedge clk); #1;
    endtask

    task automatic mem_ph(input int nb, input logic [IW-1:0] qv);
        cyc(1'b1, 1'b0, JUNK);
        for (int i = 0; i < nb; i++) cyc(1'b1, 1'b1, JUNK);
        cyc(1'b1, 1'b0, qv);
    endtask

    task automatic nop_ph();
        cyc(1'b0, 1'b0, JUNK);
    endtask

    initial begin
        int t0, dc;
        reset = 1'b0; start = 1'b0; busy = 1'b0; q = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fetch", IW'(fetch), 1);
        chk("rst_instr", instr, 0);
        chk("rst_timeout", IW'(mem_timeout), 0);
        reset = 1'b1;

        // Every phase uses memory, one busy cycle each.
        mem_ph(1, 32'hA5A5_0001);
        chk("t1_instr", instr, 32'hA5A5_0001);
        chk("t1_getregs", IW'(getRegs), 1);
        mem_ph(1, JUNK); mem_ph(1, JUNK); mem_ph(1, JUNK);
        mem_ph(1, 32'hA5A5_0002); mem_ph(1, JUNK); mem_ph(1, JUNK); mem_ph(1, JUNK);
        chk("t1_done_cnt", IW'(done_cnt), 2);
        chk("t1_done_gap", IW'(last_done - prev_done), 12);
        chk("t1_instr2", instr, 32'hA5A5_0002);

        // Arithmetic instruction: memory only in fetch, busy two cycles.
        t0 = cyc_n;
        mem_ph(2, 32'h0000_00A1); nop_ph(); nop_ph(); nop_ph();
        chk("t2_done_cycle", IW'(last_done - t0), 7);
        chk("t2_fetch", IW'(fetch), 1);

        // Stale busy during getRegs; readMem needs a fresh busy rise.
        mem_ph(1, 32'h0000_00B2);
        cyc(1'b0, 1'b1, JUNK);
        chk("t3_stale_rm", IW'(readMem), 1);
        cyc(1'b1, 1'b0, JUNK); cyc(1'b1, 1'b0, JUNK);
        chk("t3_rm_hold", IW'(readMem), 1);
        cyc(1'b1, 1'b1, JUNK); cyc(1'b1, 1'b0, JUNK);
        chk("t3_rm_adv", IW'(writeBack), 1);
        nop_ph();

        // Completion exactly on the last allowed cycle.
        mem_ph(1, 32'h0000_00C0); nop_ph();
        cyc(1'b1, 1'b0, JUNK);
        for (int i = 0; i < int'(TO) - 2; i++) cyc(1'b1, 1'b1, JUNK);
        cyc(1'b1, 1'b0, JUNK);
        chk("t4_wb", IW'(writeBack), 1);
        chk("t4_no_timeout", IW'(mem_timeout), 0);
        nop_ph();

        // Busy stuck high in readMem: abort after TO cycles.
        mem_ph(1, 32'h0000_00C3); nop_ph();
        dc = done_cnt;
        cyc(1'b1, 1'b0, JUNK);
        for (int i = 0; i < int'(TO) - 2; i++) cyc(1'b1, 1'b1, JUNK);
        chk("t5_still_rm", IW'(readMem), 1);
        cyc(1'b1, 1'b1, JUNK);
        chk("t5_fetch", IW'(fetch), 1);
        chk("t5_timeout", IW'(mem_timeout), 1);
        chk("t5_instr", instr, 32'h0000_00C3);
        chk("t5_no_done", IW'(done_cnt), IW'(dc));
        mem_ph(1, 32'h0000_00D4); nop_ph(); nop_ph(); nop_ph();
        chk("t5_sticky", IW'(mem_timeout), 1);
        chk("t5_instr_next", instr, 32'h0000_00D4);

        // Async reset mid writeBack wait.
        mem_ph(1, 32'h0000_00E0); nop_ph(); nop_ph();
        cyc(1'b1, 1'b0, JUNK); cyc(1'b1, 1'b1, JUNK);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_fetch", IW'(fetch), 1);
        chk("t6_rst_wb", IW'(writeBack), 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_timeout", IW'(mem_timeout), 0);
        start = 1'b0; busy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1'b1, 1'b0, JUNK);
        chk("t6_instr0_a", instr, 0);
        cyc(1'b1, 1'b1, JUNK);
        chk("t6_instr0_b", instr, 0);
        cyc(1'b1, 1'b0, 32'h0000_00E5);
        chk("t6_instr", instr, 32'h0000_00E5);
        nop_ph(); nop_ph(); nop_ph();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit actual=expired required=finished");
        $fatal(1, "time limit");
    end

endmodule
